// File: rtl/contadores_param.sv
// Parametrised per-channel pop counter bank with a registered, idle-gated read port.
// Supports wrap/saturate counting, sticky overflow flags, clear-on-read and global clear.
module contadores_param #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 5,
    parameter int IDX_W         = 2,
    parameter int SATURATE      = 0,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [NUM_CH-1:0] pop,
    input  logic              req,
    input  logic [IDX_W-1:0]  idx,
    input  logic              idle,
    input  logic              clr_all,
    output logic [CNT_W-1:0]  data,
    output logic              valid,
    output logic              err,
    output logic [NUM_CH-1:0] ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W:0]   NUM_CH_W = NUM_CH[IDX_W:0];

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic              rd_fire;
    logic              in_range;
    logic [CNT_W-1:0]  rd_val;
    logic [NUM_CH-1:0] cor_hit;

    assign rd_fire  = req & idle;
    assign in_range = ({1'b0, idx} < NUM_CH_W);

    // Read mux returns the pre-update value; out-of-range indices fall through to 0.
    always_comb begin
        rd_val  = '0;
        cor_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_val     = cnt_q[i];
                cor_hit[i] = (CLEAR_ON_READ != 0) && rd_fire && in_range;
            end
        end
    end

    // NOTE: the counter array is small and architecturally visible, so it takes the
    // async reset like any other register rather than being treated as a memory.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_all) begin
                    cnt_q[i] <= '0;
                    ovf[i]   <= 1'b0;
                end else if (cor_hit[i]) begin
                    // A pop landing on the read cycle survives as the first new count.
                    cnt_q[i] <= {{(CNT_W-1){1'b0}}, pop[i]};
                    ovf[i]   <= 1'b0;
                end else if (pop[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        cnt_q[i] <= (SATURATE != 0) ? CNT_MAX : '0;
                        ovf[i]   <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // which is what makes data report the count from before this edge's update.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            data  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else if (rd_fire) begin
            data  <= in_range ? rd_val : '0;
            valid <= in_range;
            err   <= ~in_range;
        end else begin
            data  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contadores_param.sv
// Self-checking bench: a wrap-mode default instance and a saturating clear-on-read
// three-channel instance, driven by a vector table plus directed corner-case sequences.
module tb_contadores_param;

    logic clk;
    logic rst_l;

    // Instance 0: defaults (NUM_CH=4, CNT_W=5, wrap, no clear-on-read)
    logic [3:0] pop0;
    logic       req0, idle0, clr0;
    logic [1:0] idx0;
    logic [4:0] data0;
    logic       valid0, err0;
    logic [3:0] ovf0;

    // Instance 1: NUM_CH=3, CNT_W=4, saturate, clear-on-read
    logic [2:0] pop1;
    logic       req1, idle1, clr1;
    logic [1:0] idx1;
    logic [3:0] data1;
    logic       valid1, err1;
    logic [2:0] ovf1;

    int n_pass  = 0;
    int n_total = 0;

    contadores_param dut0 (
        .clk(clk), .rst_l(rst_l), .pop(pop0), .req(req0), .idx(idx0), .idle(idle0),
        .clr_all(clr0), .data(data0), .valid(valid0), .err(err0), .ovf(ovf0)
    );

    contadores_param #(
        .NUM_CH(3), .CNT_W(4), .IDX_W(2), .SATURATE(1), .CLEAR_ON_READ(1)
    ) dut1 (
        .clk(clk), .rst_l(rst_l), .pop(pop1), .req(req1), .idx(idx1), .idle(idle1),
        .clr_all(clr1), .data(data1), .valid(valid1), .err(err1), .ovf(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] pop;
        logic       req;
        logic [1:0] idx;
        logic       idle;
        logic       clr;
        logic       valid;
        logic [4:0] data;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [3:0] p, input logic r, input logic [1:0] i,
                                input logic id, input logic c, input logic v,
                                input logic [4:0] d);
        vec_t t;
        t.pop = p; t.req = r; t.idx = i; t.idle = id; t.clr = c; t.valid = v; t.data = d;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step0(input logic [3:0] p, input logic r, input logic [1:0] i,
                         input logic id, input logic c);
        pop0 = p; req0 = r; idx0 = i; idle0 = id; clr0 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic [2:0] p, input logic r, input logic [1:0] i,
                         input logic id, input logic c);
        pop1 = p; req1 = r; idx1 = i; idle1 = id; clr1 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic rsp0(input string name, input logic v, input logic [4:0] d);
        check({name, ".valid"}, 32'(valid0), 32'(v));
        check({name, ".data"},  32'(data0),  32'(d));
        check({name, ".err"},   32'(err0),   32'd0);
    endtask

    task automatic rsp1(input string name, input logic v, input logic e, input logic [3:0] d);
        check({name, ".valid"}, 32'(valid1), 32'(v));
        check({name, ".err"},   32'(err1),   32'(e));
        check({name, ".data"},  32'(data1),  32'(d));
    endtask

    initial begin
        rst_l = 1'b0;
        pop0 = '0; req0 = 1'b0; idx0 = '0; idle0 = 1'b0; clr0 = 1'b0;
        pop1 = '0; req1 = 1'b0; idx1 = '0; idle1 = 1'b0; clr1 = 1'b0;

        // pop, req, idx, idle, clr -> valid, data
        vecs[0]  = mk(4'b0000, 0, 2'd0, 1, 0, 0, 5'd0);
        vecs[1]  = mk(4'b0001, 1, 2'd0, 1, 0, 1, 5'd0);  // read sees pre-pop value
        vecs[2]  = mk(4'b0011, 1, 2'd0, 1, 0, 1, 5'd1);
        vecs[3]  = mk(4'b0000, 1, 2'd1, 0, 0, 0, 5'd0);  // idle low: ignored
        vecs[4]  = mk(4'b0000, 1, 2'd1, 1, 0, 1, 5'd1);
        vecs[5]  = mk(4'b1111, 1, 2'd0, 1, 1, 1, 5'd2);  // clr_all: data is pre-clear
        vecs[6]  = mk(4'b0000, 1, 2'd0, 1, 0, 1, 5'd0);
        vecs[7]  = mk(4'b1111, 0, 2'd0, 1, 0, 0, 5'd0);
        vecs[8]  = mk(4'b1110, 0, 2'd0, 1, 0, 0, 5'd0);
        vecs[9]  = mk(4'b1100, 0, 2'd0, 1, 0, 0, 5'd0);
        vecs[10] = mk(4'b1000, 0, 2'd0, 1, 0, 0, 5'd0);  // counts now 1,2,3,4
        vecs[11] = mk(4'b0000, 1, 2'd0, 1, 0, 1, 5'd1);  // back-to-back reads
        vecs[12] = mk(4'b0000, 1, 2'd1, 1, 0, 1, 5'd2);
        vecs[13] = mk(4'b0000, 1, 2'd2, 1, 0, 1, 5'd3);
        vecs[14] = mk(4'b1000, 1, 2'd3, 1, 0, 1, 5'd4);
        vecs[15] = mk(4'b0000, 1, 2'd3, 1, 0, 1, 5'd5);
        vecs[16] = mk(4'b0000, 0, 2'd0, 1, 1, 0, 5'd0);

        #2;
        check("reset.valid0", 32'(valid0), 32'd0);
        check("reset.data0",  32'(data0),  32'd0);
        check("reset.err0",   32'(err0),   32'd0);
        check("reset.ovf0",   32'(ovf0),   32'd0);
        check("reset.ovf1",   32'(ovf1),   32'd0);
        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;

        for (int k = 0; k < 17; k++) begin
            step0(vecs[k].pop, vecs[k].req, vecs[k].idx, vecs[k].idle, vecs[k].clr);
            rsp0($sformatf("vec%0d", k), vecs[k].valid, vecs[k].data);
            check($sformatf("vec%0d.ovf", k), 32'(ovf0), 32'd0);
        end

        // Wrap: 31 pops reach the max with no overflow, 2 more wrap to 1 and set ovf.
        for (int k = 0; k < 31; k++) step0(4'b0100, 0, 2'd0, 1, 0);
        check("wrap.ovf_at_max", 32'(ovf0), 32'd0);
        step0(4'b0000, 1, 2'd2, 1, 0);
        rsp0("wrap.read31", 1, 5'd31);
        for (int k = 0; k < 2; k++) step0(4'b0100, 0, 2'd0, 1, 0);
        step0(4'b0000, 1, 2'd2, 1, 0);
        rsp0("wrap.read1", 1, 5'd1);
        check("wrap.ovf", 32'(ovf0), 32'h4);
        step0(4'b0000, 1, 2'd0, 1, 0);
        rsp0("wrap.other0", 1, 5'd0);
        step0(4'b0000, 1, 2'd3, 1, 0);
        rsp0("wrap.other3", 1, 5'd0);

        // Async reset while a response is showing.
        for (int k = 0; k < 3; k++) step0(4'b0001, 0, 2'd0, 1, 0);
        step0(4'b0000, 1, 2'd0, 1, 0);
        rsp0("arst.pre", 1, 5'd3);
        #2 rst_l = 1'b0;
        #1;
        check("arst.valid", 32'(valid0), 32'd0);
        check("arst.data",  32'(data0),  32'd0);
        check("arst.ovf",   32'(ovf0),   32'd0);
        check("arst.err",   32'(err0),   32'd0);
        @(posedge clk);
        #1;
        check("arst.held_valid", 32'(valid0), 32'd0);
        rst_l = 1'b1;
        step0(4'b0000, 1, 2'd0, 1, 0);
        rsp0("arst.cnt_cleared", 1, 5'd0);
        step0(4'b0000, 0, 2'd0, 1, 0);

        // Saturate: 15 pops reach max with no ovf; 5 more hold at 15 and set ovf.
        for (int k = 0; k < 15; k++) step1(3'b001, 0, 2'd0, 1, 0);
        check("sat.ovf_at_max", 32'(ovf1), 32'd0);
        for (int k = 0; k < 5; k++) step1(3'b001, 0, 2'd0, 1, 0);
        check("sat.ovf", 32'(ovf1), 32'd1);
        step1(3'b000, 1, 2'd0, 1, 0);
        rsp1("sat.read", 1, 0, 4'd15);
        check("cor.ovf_cleared", 32'(ovf1), 32'd0);
        step1(3'b000, 1, 2'd0, 1, 0);
        rsp1("cor.reread", 1, 0, 4'd0);

        // Clear-on-read with a simultaneous pop.
        for (int k = 0; k < 7; k++) step1(3'b010, 0, 2'd0, 1, 0);
        step1(3'b010, 1, 2'd1, 1, 0);
        rsp1("cor.pop_read", 1, 0, 4'd7);
        step1(3'b000, 1, 2'd1, 1, 0);
        rsp1("cor.pop_kept", 1, 0, 4'd1);
        check("cor.pop_ovf", 32'(ovf1), 32'd0);

        // Read coinciding with clr_all returns the pre-clear value.
        for (int k = 0; k < 3; k++) step1(3'b100, 0, 2'd0, 1, 0);
        step1(3'b100, 1, 2'd2, 1, 1);
        rsp1("clr.read", 1, 0, 4'd3);
        step1(3'b000, 1, 2'd2, 1, 0);
        rsp1("clr.after", 1, 0, 4'd0);

        // clr_all alone drops a sticky ovf.
        for (int k = 0; k < 16; k++) step1(3'b001, 0, 2'd0, 1, 0);
        check("clr.ovf_set", 32'(ovf1), 32'd1);
        step1(3'b001, 0, 2'd0, 1, 1);
        check("clr.ovf_cleared", 32'(ovf1), 32'd0);
        step1(3'b000, 1, 2'd0, 1, 0);
        rsp1("clr.cnt", 1, 0, 4'd0);

        // Idle gating and out-of-range index.
        for (int k = 0; k < 2; k++) step1(3'b001, 0, 2'd0, 1, 0);
        step1(3'b000, 1, 2'd0, 0, 0);
        rsp1("gate.idle_low", 0, 0, 4'd0);
        step1(3'b000, 1, 2'd3, 1, 0);
        rsp1("range.err", 0, 1, 4'd0);
        step1(3'b000, 0, 2'd0, 1, 0);
        rsp1("range.err_drop", 0, 0, 4'd0);
        step1(3'b000, 1, 2'd0, 1, 0);
        rsp1("range.cnt_kept", 1, 0, 4'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
